// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizing for the two-port RAM arbiter.
package ram_arbiter_pkg;

    // INIT: zeroing sweep in progress; RUN: arbitrating requester traffic.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer to use next.
// i_ptr names the requester that wins when both are valid.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_next_ptr
);

    // Pick a winner and hand priority to the loser; hold priority when idle.
    always_comb begin
        o_grant    = 2'b00;
        o_next_ptr = i_ptr;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
        if (o_grant[0]) begin
            o_next_ptr = 1'b1;
        end else if (o_grant[1]) begin
            o_next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single-port-pair RAM after zeroing it.
// Read data is forwarded straight from the RAM's registered output; only the
// response strobe is registered here, so it lines up with rd_data.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    wr_enb,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    rd_enb,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    init_done
);

    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_sweep;
    logic                    r_ptr;
    logic                    r_init_done;
    logic [1:0]              r_rsp_valid;

    logic [1:0]              w_arb_valid;
    logic [1:0]              w_grant;
    logic                    w_next_ptr;
    logic                    w_win;
    logic                    w_win_we;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic [DATA_WIDTH-1:0]   w_win_wdata;

    // Requests are invisible to the arbiter until the sweep has finished.
    assign w_arb_valid = (r_state == ST_RUN) ? req_valid : 2'b00;

    rr_arb2 u_arb (
        .i_valid    (w_arb_valid),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    assign w_win       = w_grant[1];
    assign w_win_we    = req_we[w_win];
    assign w_win_addr  = req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_wdata = req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = rd_data;
    assign init_done = r_init_done;

    // Steer the RAM ports: sweep writes during INIT, winner's access in RUN.
    always_comb begin
        wr_enb  = 1'b0;
        wr_addr = w_win_addr;
        wr_data = w_win_wdata;
        rd_enb  = 1'b0;
        rd_addr = w_win_addr;
        if (r_state == ST_INIT) begin
            wr_enb  = 1'b1;
            wr_addr = r_sweep;
            wr_data = '0;
        end else if (|w_grant) begin
            if (w_win_we) begin
                wr_enb = 1'b1;
            end else begin
                rd_enb = 1'b1;
            end
        end
    end

    // Sequencer: sweep counter, priority pointer and response strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_sweep     <= '0;
            r_ptr       <= 1'b0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 2'b00;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rsp_valid <= 2'b00;
                    if (r_sweep == SWEEP_LAST) begin
                        r_sweep     <= '0;
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_sweep <= r_sweep + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ptr       <= w_next_ptr;
                    r_rsp_valid <= (|w_grant && !w_win_we) ? w_grant : 2'b00;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-read RAM.
// Read responses are checked by a scoreboard monitor decoupled from stimulus.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        wr_enb;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_enb;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        init_done;

    ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .wr_enb    (wr_enb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_enb    (rd_enb),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read, never reset.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (wr_enb) mem[wr_addr] <= wr_data;
        if (rd_enb) rd_data <= mem[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0] mask;
        logic [7:0] data;
        int         c;
    } exp_t;
    exp_t q[$];

    // Monitor: every response strobe must match the oldest expected entry,
    // and each entry must be answered in the cycle after its grant.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid != 2'b00) begin
            if (q.size() == 0 || q[0].c >= cyc) begin
                chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.mask});
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
            end
        end else if (q.size() > 0 && q[0].c < cyc) begin
            e = q.pop_front();
            chk("rsp_missing", {30'd0, rsp_valid}, {30'd0, e.mask});
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    // Check one RUN cycle at the falling edge, queue any read response,
    // then move to just after the next rising edge.
    task automatic step(input string name, input logic [1:0] exp_ready, input logic [7:0] exp_rd);
        exp_t e;
        int w;
        logic [3:0] a;
        logic [7:0] d;
        @(negedge clk);
        chk({name, "_ready"}, {30'd0, req_ready}, {30'd0, exp_ready});
        if (exp_ready == 2'b00) begin
            chk({name, "_idle_ports"}, {30'd0, wr_enb, rd_enb}, 32'd0);
        end else begin
            w = exp_ready[1] ? 1 : 0;
            a = req_addr[w*4 +: 4];
            d = req_wdata[w*8 +: 8];
            if (req_we[w]) begin
                chk({name, "_wr_en"}, {30'd0, wr_enb, rd_enb}, 32'd2);
                chk({name, "_wr_addr"}, {28'd0, wr_addr}, {28'd0, a});
                chk({name, "_wr_data"}, {24'd0, wr_data}, {24'd0, d});
            end else begin
                chk({name, "_rd_en"}, {30'd0, wr_enb, rd_enb}, 32'd1);
                chk({name, "_rd_addr"}, {28'd0, rd_addr}, {28'd0, a});
                e.mask = exp_ready;
                e.data = exp_rd;
                e.c    = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Sixteen zeroing writes with requests locked out, then init_done.
    task automatic sweep(input string name);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk({name, "_wr_enb"}, {31'd0, wr_enb}, 32'd1);
            chk({name, "_wr_addr"}, {28'd0, wr_addr}, i);
            chk({name, "_wr_data"}, {24'd0, wr_data}, 32'd0);
            chk({name, "_ready"}, {30'd0, req_ready}, 32'd0);
            chk({name, "_init_low"}, {31'd0, init_done}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk({name, "_init_done"}, {31'd0, init_done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0);
        #1;
        chk("reset_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_init_done", {31'd0, init_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Init sweep with no requests.
        sweep("sweep1");

        // Requester 0: write 0xA5 to 3, read it back.
        drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
        step("r0_wr3", 2'b01, 8'h00);
        drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
        step("r0_rd3", 2'b01, 8'hA5);

        // Requester 1 writes 15, requester 0 reads it on the very next cycle.
        drive(2'b10, 2'b10, 4'd0, 4'd15, 8'h00, 8'h3C);
        step("r1_wr15", 2'b10, 8'h00);
        drive(2'b01, 2'b00, 4'd15, 4'd0, 8'h00, 8'h00);
        step("r0_rd15", 2'b01, 8'h3C);

        // Lone requester 1 wins even though pointer favours it anyway; ptr -> 0.
        drive(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
        step("r1_rd3", 2'b10, 8'hA5);

        // Both reading continuously: alternate 01,10,01,10.
        drive(2'b11, 2'b00, 4'd3, 4'd15, 8'h00, 8'h00);
        step("both_a", 2'b01, 8'hA5);
        step("both_b", 2'b10, 8'h3C);
        step("both_c", 2'b01, 8'hA5);
        step("both_d", 2'b10, 8'h3C);

        // Idle cycle holds the pointer at requester 0.
        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        step("idle", 2'b00, 8'h00);
        drive(2'b11, 2'b00, 4'd3, 4'd15, 8'h00, 8'h00);
        step("after_idle", 2'b01, 8'hA5);
        step("after_idle2", 2'b10, 8'h3C);

        // Read by requester 0 moves pointer to 1, then reset hits with the
        // response strobe active.
        drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
        step("pre_rst_rd", 2'b01, 8'hA5);
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        drive(2'b11, 2'b00, 4'd3, 4'd15, 8'h00, 8'h00);
        @(negedge clk);
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_hold", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sweep restarts at 0 with both requesters held off, then requester 0
        // wins first because the pointer was reset; memory is zero again.
        sweep("sweep2");
        step("post_rst_a", 2'b01, 8'h00);
        step("post_rst_b", 2'b10, 8'h00);

        drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        step("drain", 2'b00, 8'h00);
        step("drain2", 2'b00, 8'h00);
        chk("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
